sat_vpe_tm: RTL and testbench

- Parametrised, time-multiplexed variable processing element for the stochastic SAT solver array.
- Owns one variable and its clause-membership table for N_CLAUSE clauses.
- Scans the table LANES clauses per cycle to count make/break, then decides a flip with greedy, tie-break and stochastic rules.
- Drives the variable bus, and SATISFY into the systolic up/left chain.

---
 rtl/sat_vpe_tm.sv | 214 +++++++++++++++++++++
 tb/tb_sat_vpe_tm.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_vpe_tm.sv
// sat_vpe_tm: variable PE for the stochastic SAT array; scans its clause table LANES/cycle, then flips greedily/by tie-break.
// Latency: START at cycle t -> DONE pulse, new VI_BUS/FLIPPED/counts at t+BEATS+1 (BUSY high t+1..t+BEATS).
// Backpressure: none; START, CFG_WE and VAR_LD outside IDLE are dropped. Optional random walk: `define SAT_VPE_NOISE_EN.
module sat_vpe_tm #(
  parameter  int N_CLAUSE = 32,
  parameter  int LANES    = 8,
  parameter  int LFSR_W   = 16,
  localparam int AW       = $clog2(N_CLAUSE),
  localparam int CW       = $clog2(N_CLAUSE + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cfg_we,
  input  logic [AW-1:0]       i_cfg_addr,
  input  logic [1:0]          i_cfg_data,
  input  logic                i_var_ld,
  input  logic                i_var_in,
  input  logic                i_start,
  input  logic                i_stochastic_mode,
  input  logic                i_seed_ld,
  input  logic [LFSR_W-1:0]   i_seed,
  input  logic [7:0]          i_noise_th,
  input  logic [N_CLAUSE-1:0] i_clause_sat_oth,
  input  logic                i_satisfy_up,
  input  logic                i_satisfy_left,
  output logic                o_vi_bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_flipped,
  output logic [CW-1:0]       o_make_cnt,
  output logic [CW-1:0]       o_break_cnt,
  output logic [15:0]         o_flip_cnt,
  output logic                o_satisfy
);

  localparam int BEATS = N_CLAUSE / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LFSR_W-1:0] LFSR_RST = LFSR_W'(16'hACE1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_DECIDE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [N_CLAUSE-1:0] r_member;
  logic [N_CLAUSE-1:0] r_sign;
  logic [N_CLAUSE-1:0] r_oth;
  logic                r_vi;
  logic                r_flipped;
  logic [BW-1:0]       r_beat;
  logic [CW-1:0]       r_make_acc;
  logic [CW-1:0]       r_break_acc;
  logic [CW-1:0]       r_make_cnt;
  logic [CW-1:0]       r_break_cnt;
  logic [15:0]         r_flip_cnt;
  logic [LFSR_W-1:0]   r_lfsr;

  logic [N_CLAUSE-1:0] w_lit;
  logic [N_CLAUSE-1:0] w_make_vec;
  logic [N_CLAUSE-1:0] w_break_vec;
  logic [N_CLAUSE-1:0] w_make_sh;
  logic [N_CLAUSE-1:0] w_break_sh;
  logic [CW-1:0]       w_make_beat;
  logic [CW-1:0]       w_break_beat;
  logic [CW-1:0]       w_make_tot;
  logic [CW-1:0]       w_break_tot;
  logic                w_last_beat;
  logic                w_decide;
  logic                w_noise;
  logic                w_flip;
  logic                w_idle;
  logic                w_lfsr_fb;
  logic [LFSR_W-1:0]   w_lfsr_nxt;

  // Literal truth per clause; make/break use the START-time snapshot of the other variables.
  assign w_lit       = r_sign ^ {N_CLAUSE{r_vi}};
  assign w_make_vec  = r_member & ~r_oth & ~w_lit;
  assign w_break_vec = r_member & ~r_oth &  w_lit;
  assign w_make_sh   = w_make_vec  >> (r_beat * LANES);
  assign w_break_sh  = w_break_vec >> (r_beat * LANES);

  // Popcount of the current LANES-wide window of make/break bits.
  always_comb begin
    w_make_beat  = '0;
    w_break_beat = '0;
    for (int l = 0; l < LANES; l++) begin
      w_make_beat  = w_make_beat  + CW'(w_make_sh[l]);
      w_break_beat = w_break_beat + CW'(w_break_sh[l]);
    end
  end

  assign w_make_tot  = r_make_acc  + w_make_beat;
  assign w_break_tot = r_break_acc + w_break_beat;
  assign w_idle      = (r_state == S_IDLE);
  assign w_last_beat = (r_beat == BW'(BEATS - 1));
  // The final beat's totals feed the decision directly, so results land as DECIDE is entered.
  assign w_decide    = (r_state == S_EVAL) && w_last_beat;

`ifdef SAT_VPE_NOISE_EN
  assign w_noise = i_stochastic_mode && (r_lfsr[15:8] < i_noise_th);
`else
  logic w_noise_th_unused;
  assign w_noise_th_unused = ^i_noise_th;
  assign w_noise = 1'b0;
`endif

  assign w_flip = (w_make_tot > w_break_tot)
               || ((w_make_tot == w_break_tot) && i_stochastic_mode && r_lfsr[0])
               || w_noise;

  // Right-shifting Fibonacci LFSR for x^16+x^14+x^13+x^11+1.
  assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_lfsr_nxt = {w_lfsr_fb, r_lfsr[LFSR_W-1:1]};

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: IDLE -> EVAL on START, EVAL for BEATS cycles, one DECIDE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_EVAL;
      S_EVAL:   if (w_last_beat) w_state_nxt = S_DECIDE;
      S_DECIDE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Clause table: writable only in IDLE so it stays stable during a scan.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_member <= '0;
      r_sign   <= '0;
    end else if (i_cfg_we && w_idle) begin
      r_member[i_cfg_addr] <= i_cfg_data[1];
      r_sign[i_cfg_addr]   <= i_cfg_data[0];
    end
  end

  // Variable value: external load in IDLE, otherwise toggled by the decision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vi      <= 1'b0;
      r_flipped <= 1'b0;
    end else if (i_var_ld && w_idle) begin
      r_vi      <= i_var_in;
      r_flipped <= 1'b0;
    end else if (w_decide) begin
      r_vi      <= r_vi ^ w_flip;
      r_flipped <= w_flip;
    end
  end

  // Scan bookkeeping: snapshot and clear on START, accumulate one window per EVAL cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_oth       <= '0;
      r_beat      <= '0;
      r_make_acc  <= '0;
      r_break_acc <= '0;
    end else if (w_idle && i_start) begin
      r_oth       <= i_clause_sat_oth;
      r_beat      <= '0;
      r_make_acc  <= '0;
      r_break_acc <= '0;
    end else if (r_state == S_EVAL) begin
      r_beat      <= r_beat + 1'b1;
      r_make_acc  <= w_make_tot;
      r_break_acc <= w_break_tot;
    end
  end

  // Published results of the last decision, with a saturating flip counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_make_cnt  <= '0;
      r_break_cnt <= '0;
      r_flip_cnt  <= '0;
    end else if (w_decide) begin
      r_make_cnt  <= w_make_tot;
      r_break_cnt <= w_break_tot;
      if (w_flip && (r_flip_cnt != 16'hFFFF)) r_flip_cnt <= r_flip_cnt + 16'd1;
    end
  end

  // LFSR: seed load in any state (zero seed maps to the reset value), one step per decision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_RST;
    end else if (i_seed_ld) begin
      r_lfsr <= (i_seed == '0) ? LFSR_RST : i_seed;
    end else if (w_decide) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  assign o_vi_bus    = r_vi;
  assign o_busy      = (r_state == S_EVAL);
  assign o_done      = (r_state == S_DECIDE);
  assign o_flipped   = r_flipped;
  assign o_make_cnt  = r_make_cnt;
  assign o_break_cnt = r_break_cnt;
  assign o_flip_cnt  = r_flip_cnt;
  // Systolic chain uses the live neighbour inputs, not the scan snapshot.
  assign o_satisfy   = (&(~r_member | i_clause_sat_oth | w_lit)) & i_satisfy_up & i_satisfy_left;

endmodule

// File: tb/tb_sat_vpe_tm.sv
// tb_sat_vpe_tm: scoreboard bench for sat_vpe_tm with a clause-list reference model.
// Latency: expected results are queued at START and popped when DONE appears.
// Backpressure: none; START/config activity during a scan is expected to be ignored.
module tb_sat_vpe_tm;

  localparam int N     = 32;
  localparam int LANES = 8;
  localparam int BEATS = N / LANES;
  localparam int AW    = $clog2(N);
  localparam int CW    = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [1:0]    cfg_data;
  logic          var_ld, var_in, start, stoch, seed_ld;
  logic [15:0]   seed;
  logic [7:0]    noise_th;
  logic [N-1:0]  oth;
  logic          sat_up, sat_left;
  logic          vi_bus, busy, done, flipped, satisfy;
  logic [CW-1:0] make_cnt, break_cnt;
  logic [15:0]   flip_cnt;

  always #5 clk = ~clk;

  sat_vpe_tm #(.N_CLAUSE(N), .LANES(LANES), .LFSR_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
    .i_cfg_data(cfg_data), .i_var_ld(var_ld), .i_var_in(var_in), .i_start(start),
    .i_stochastic_mode(stoch), .i_seed_ld(seed_ld), .i_seed(seed), .i_noise_th(noise_th),
    .i_clause_sat_oth(oth), .i_satisfy_up(sat_up), .i_satisfy_left(sat_left),
    .o_vi_bus(vi_bus), .o_busy(busy), .o_done(done), .o_flipped(flipped),
    .o_make_cnt(make_cnt), .o_break_cnt(break_cnt), .o_flip_cnt(flip_cnt),
    .o_satisfy(satisfy)
  );

  typedef struct {
    int cyc;
    int mk;
    int bk;
    int vi;
    int fl;
    int fc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state: a plain list of clauses and the variable.
  bit m_member[N];
  bit m_sign[N];
  bit m_vi;
  int m_lfsr;
  int m_fc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int lfsr_step(input int x);
    int fb;
    fb = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return ((x >> 1) | (fb << 15)) & 32'hFFFF;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_member[c] = 1'b0;
      m_sign[c]   = 1'b0;
    end
    m_vi   = 1'b0;
    m_lfsr = 32'hACE1;
    m_fc   = 0;
  endtask

  function automatic int model_sat();
    int s;
    s = 1;
    for (int c = 0; c < N; c++)
      if (m_member[c] && !oth[c] && !(m_vi ^ m_sign[c])) s = 0;
    return s & int'(sat_up) & int'(sat_left);
  endfunction

  // Count make/break over the whole clause list, apply the flip rules, queue the expected result.
  task automatic model_eval(input int start_cyc);
    int   mk, bk;
    bit   fl;
    exp_t e;
    mk = 0;
    bk = 0;
    for (int c = 0; c < N; c++) begin
      if (m_member[c] && !oth[c]) begin
        if (m_vi ^ m_sign[c]) bk++;
        else                  mk++;
      end
    end
    fl = (mk > bk) || ((mk == bk) && stoch && ((m_lfsr & 1) == 1));
`ifdef SAT_VPE_NOISE_EN
    if (stoch && (((m_lfsr >> 8) & 255) < int'(noise_th))) fl = 1'b1;
`endif
    m_vi = m_vi ^ fl;
    if (fl && m_fc != 65535) m_fc++;
    m_lfsr = lfsr_step(m_lfsr);
    e.cyc = start_cyc + BEATS + 1;
    e.mk  = mk;
    e.bk  = bk;
    e.vi  = int'(m_vi);
    e.fl  = int'(fl);
    e.fc  = m_fc;
    sbq.push_back(e);
  endtask

  task automatic wr(input int a, input bit m, input bit s);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = {m, s};
    @(negedge clk);
    cfg_we   = 1'b0;
    m_member[a] = m;
    m_sign[a]   = s;
  endtask

  task automatic var_load(input bit v);
    var_ld = 1'b1;
    var_in = v;
    @(negedge clk);
    var_ld = 1'b0;
    m_vi   = v;
  endtask

  task automatic seed_load(input logic [15:0] s);
    seed_ld = 1'b1;
    seed    = s;
    @(negedge clk);
    seed_ld = 1'b0;
    m_lfsr  = (s == 16'h0) ? 32'hACE1 : int'(s);
  endtask

  task automatic do_start(input bit with_ld, input bit ld_val);
    if (with_ld) begin
      var_ld = 1'b1;
      var_in = ld_val;
      m_vi   = ld_val;
    end
    model_eval(cyc);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    var_ld = 1'b0;
  endtask

  // Wait (bounded) for DONE; optionally hammer ignored inputs while the scan runs.
  task automatic wait_done(input bit junk);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * BEATS + 8; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (junk) begin
        cfg_we   = 1'($urandom_range(0, 1));
        cfg_addr = AW'($urandom);
        cfg_data = 2'($urandom);
        var_ld   = 1'($urandom_range(0, 1));
        var_in   = 1'($urandom_range(0, 1));
        start    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
    var_ld = 1'b0;
    start  = 1'b0;
    chk("done_seen", int'(seen), 1);
    @(negedge clk);
  endtask

  // Monitor: every DONE pops one expectation and compares all published results.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_latency", cyc, mon_e.cyc);
          chk("make_cnt", int'(make_cnt), mon_e.mk);
          chk("break_cnt", int'(break_cnt), mon_e.bk);
          chk("vi_bus", int'(vi_bus), mon_e.vi);
          chk("flipped", int'(flipped), mon_e.fl);
          chk("flip_cnt", int'(flip_cnt), mon_e.fc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    var_ld = 1'b0; var_in = 1'b0; start = 1'b0; stoch = 1'b0;
    seed_ld = 1'b0; seed = '0; noise_th = '0; oth = '0;
    sat_up = 1'b1; sat_left = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_vi", int'(vi_bus), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flipped", int'(flipped), 0);
    chk("rst_make", int'(make_cnt), 0);
    chk("rst_break", int'(break_cnt), 0);
    chk("rst_flip_cnt", int'(flip_cnt), 0);
    chk("rst_satisfy", int'(satisfy), 1);

    // Make > break: three positive literals unsatisfied, one negated literal true
    wr(0, 1, 0); wr(1, 1, 0); wr(2, 1, 0); wr(3, 1, 1);
    do_start(1'b0, 1'b0);
    wait_done(1'b0);
    chk("t1_make", int'(make_cnt), 3);
    chk("t1_break", int'(break_cnt), 1);
    chk("t1_vi", int'(vi_bus), 1);
    chk("t1_flipped", int'(flipped), 1);
    chk("t1_flip_cnt", int'(flip_cnt), 1);

    // Deterministic tie
    wr(2, 0, 0); wr(3, 0, 0); wr(1, 1, 1);
    var_load(1'b0);
    chk("ld_clears_flipped", int'(flipped), 0);
    do_start(1'b0, 1'b0);
    wait_done(1'b0);
    chk("t2_make", int'(make_cnt), 1);
    chk("t2_break", int'(break_cnt), 1);
    chk("t2_vi", int'(vi_bus), 0);
    chk("t2_flipped", int'(flipped), 0);

    // Stochastic tie with seed 1, then one more tie against the model's LFSR sequence
    seed_load(16'h0001);
    stoch = 1'b1;
    do_start(1'b0, 1'b0);
    wait_done(1'b0);
    chk("t3_vi", int'(vi_bus), 1);
    chk("t3_flipped", int'(flipped), 1);
    do_start(1'b0, 1'b0);
    wait_done(1'b0);
    stoch = 1'b0;

    // START while busy is ignored
    dones = 0;
    do_start(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t4_busy_t%0d", i), int'(busy), (i <= BEATS) ? 1 : 0);
      if (done) dones++;
      start = (i == 2);
      @(negedge clk);
    end
    start = 1'b0;
    chk("t4_one_done", dones, 1);

    // Reset in the middle of a scan
    var_load(1'b1);
    do_start(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_vi", int'(vi_bus), 0);
    chk("t5_flip_cnt", int'(flip_cnt), 0);
    sbq.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BEATS + 2) @(negedge clk);
    chk("t5_table_cleared_sat", int'(satisfy), 1);
    do_start(1'b0, 1'b0);
    wait_done(1'b0);

    // SATISFY chain
    wr(5, 1, 0);
    oth = '0;
    #1 chk("t6_sat_unsat", int'(satisfy), 0);
    oth[5] = 1'b1;
    #1 chk("t6_sat_oth", int'(satisfy), 1);
    sat_left = 1'b0;
    #1 chk("t6_sat_left", int'(satisfy), 0);
    sat_left = 1'b1;
    @(negedge clk);

    // Randomised scans, with ignored traffic driven during each scan
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < int'($urandom_range(1, 6)); k++)
        wr(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0)
        seed_load(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
      oth      = N'($urandom & $urandom);
      stoch    = 1'($urandom_range(0, 1));
      noise_th = 8'($urandom);
      sat_up   = ($urandom_range(0, 7) != 0);
      #1 chk("rnd_satisfy", int'(satisfy), model_sat());
      sat_up = 1'b1;
      do_start($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      wait_done(1'b1);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
